// File: rtl/plab4_net_router_output_ctrl.sv
//------------------------------------------------------------------------
// plab4_net_router_output_ctrl
//
// Per-output-port arbiter for the one-way ring router. Picks one of the
// three input-port requests, returns one-hot grants to the input controls,
// drives the crossbar select and the output valid. A grant-hold state
// keeps a stalled winner selected until its transfer completes.
//
// Optional feature macro: PLAB4_NET_ROUTER_OUTPUT_CTRL_RR_EN
//   defined   : round-robin pointer advances past each transfer winner
//   undefined : fixed circular priority starting at p_default_prio
//------------------------------------------------------------------------

module plab4_net_router_output_ctrl #(
  parameter logic [2:0] p_default_prio = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       domain_ID,
  input  logic [2:0] reqs,
  output logic [2:0] grants,
  output logic [1:0] sel,
  output logic       out_val,
  input  logic       out_rdy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     state_r;
  logic [2:0] hold_win_r;
  logic [1:0] sel_q_r;
  logic [2:0] prio_s;
  logic [2:0] win_s;
  logic       held_live_s;
  logic       xfer_s;

  // The security label only travels with the port; no logic depends on it.
  logic       unused_domain_s;
  assign unused_domain_s = domain_ID;

  // One-hot rotate left by one: the input after v becomes the new head.
  function automatic logic [2:0] rotl1(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  // First requester found scanning circularly from the one-hot pointer p.
  function automatic logic [2:0] rr_pick(input logic [2:0] r,
                                         input logic [2:0] p);
    logic [2:0] cand;
    logic [2:0] pick;
    pick = 3'b000;
    cand = p;
    for (int k = 0; k < 3; k++) begin
      if ((pick == 3'b000) && ((r & cand) != 3'b000)) begin
        pick = cand;
      end else begin
        pick = pick;
      end
      cand = rotl1(cand);
    end
    return pick;
  endfunction

  // One-hot to binary index; an empty vector keeps the previous select.
  function automatic logic [1:0] onehot_to_bin(input logic [2:0] v,
                                               input logic [1:0] fallback);
    logic [1:0] b;
    case (v)
      3'b001:  b = 2'd0;
      3'b010:  b = 2'd1;
      3'b100:  b = 2'd2;
      default: b = fallback;
    endcase
    return b;
  endfunction

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_RR_EN
  logic [2:0] prio_r;
  assign prio_s = prio_r;
`else
  assign prio_s = p_default_prio;
`endif

  // Winner selection: a held winner that still requests wins outright,
  // otherwise arbitrate from the pointer; nothing wins during reset.
  always_comb begin
    held_live_s = |(reqs & hold_win_r);
    if (reset) begin
      win_s = 3'b000;
    end else if ((state_r == ST_HOLD) && held_live_s) begin
      win_s = hold_win_r;
    end else begin
      win_s = rr_pick(reqs, prio_s);
    end
    out_val = |win_s;
    grants  = win_s & {3{out_rdy}};
    if (reset) begin
      sel = 2'd0;
    end else begin
      sel = onehot_to_bin(win_s, sel_q_r);
    end
    xfer_s = out_val & out_rdy;
  end

  // Hold FSM, remembered select and (optionally) round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      hold_win_r <= 3'b000;
      sel_q_r    <= 2'd0;
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_RR_EN
      prio_r     <= p_default_prio;
`endif
    end else begin
      sel_q_r <= sel;
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_RR_EN
      if (xfer_s) begin
        prio_r <= rotl1(win_s);
      end else begin
        prio_r <= prio_r;
      end
`endif
      case (state_r)
        ST_IDLE: begin
          if (out_val && !out_rdy) begin
            state_r    <= ST_HOLD;
            hold_win_r <= win_s;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Leave on a transfer, or when the held requester withdrew
          // (that cycle was already re-arbitrated from the pointer).
          if (xfer_s || !held_live_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
